// File: rtl/kd_input_dispatch.sv
// Splits the host word stream into KD-tree node, leaf-patch and query-patch writes.
// Records are assembled word by word and emitted as single registered write strobes.
module kd_input_dispatch #(
    parameter int unsigned DATA_WIDTH   = 11,
    parameter int unsigned PATCH_SIZE   = 5,
    parameter int unsigned LEAF_SIZE    = 8,
    parameter int unsigned NUM_LEAVES   = 64,
    parameter int unsigned NUM_NODES    = NUM_LEAVES - 1,
    parameter int unsigned NUM_QUERYS   = 494,
    parameter int unsigned LEAF_ADDR_W  = $clog2(NUM_LEAVES),
    parameter int unsigned QUERY_ADDR_W = $clog2(NUM_QUERYS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_kdtree,
    input  logic [DATA_WIDTH-1:0]              fifo_rdata,
    input  logic                               fifo_rempty_n,
    output logic                               fifo_deq,
    output logic                               node_wen,
    output logic [LEAF_ADDR_W-1:0]             node_waddr,
    output logic [2:0]                         node_dim,
    output logic [DATA_WIDTH-1:0]              node_median,
    output logic                               leaf_wen,
    output logic [LEAF_ADDR_W-1:0]             leaf_waddr,
    output logic [2:0]                         leaf_slot,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0]   leaf_patch,
    output logic [DATA_WIDTH-1:0]              leaf_patch_idx,
    output logic                               query_wen,
    output logic [QUERY_ADDR_W-1:0]            query_waddr,
    output logic [PATCH_SIZE*DATA_WIDTH-1:0]   query_patch,
    output logic                               kdtree_loaded,
    output logic                               queries_loaded,
    output logic                               protocol_err
);

    localparam int unsigned WCNT_W = $clog2(PATCH_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NODES   = 3'd1,
        LEAVES  = 3'd2,
        QUERIES = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                                 state;
    logic [WCNT_W-1:0]                      wcnt;
    logic [LEAF_ADDR_W-1:0]                 node_cnt;
    logic [LEAF_ADDR_W-1:0]                 leaf_cnt;
    logic [2:0]                             slot_cnt;
    logic [QUERY_ADDR_W-1:0]                query_cnt;
    logic [DATA_WIDTH-1:0]                  dim_word;
    logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]  pbuf;

    // Pop whenever a word is available in a loading state; a restart pulse blocks the pop.
    assign fifo_deq = fifo_rempty_n && !load_kdtree &&
                      ((state == NODES) || (state == LEAVES) || (state == QUERIES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wcnt           <= '0;
            node_cnt       <= '0;
            leaf_cnt       <= '0;
            slot_cnt       <= '0;
            query_cnt      <= '0;
            dim_word       <= '0;
            pbuf           <= '0;
            node_wen       <= 1'b0;
            node_waddr     <= '0;
            node_dim       <= '0;
            node_median    <= '0;
            leaf_wen       <= 1'b0;
            leaf_waddr     <= '0;
            leaf_slot      <= '0;
            leaf_patch     <= '0;
            leaf_patch_idx <= '0;
            query_wen      <= 1'b0;
            query_waddr    <= '0;
            query_patch    <= '0;
            kdtree_loaded  <= 1'b0;
            queries_loaded <= 1'b0;
            protocol_err   <= 1'b0;
        end else begin
            node_wen  <= 1'b0;
            leaf_wen  <= 1'b0;
            query_wen <= 1'b0;
            if (load_kdtree) begin
                state          <= NODES;
                wcnt           <= '0;
                node_cnt       <= '0;
                leaf_cnt       <= '0;
                slot_cnt       <= '0;
                query_cnt      <= '0;
                kdtree_loaded  <= 1'b0;
                queries_loaded <= 1'b0;
                protocol_err   <= 1'b0;
            end else if (fifo_deq) begin
                case (state)
                    NODES: begin
                        if (wcnt == '0) begin
                            dim_word <= fifo_rdata;
                            wcnt     <= WCNT_W'(1);
                        end else begin
                            wcnt        <= '0;
                            node_wen    <= 1'b1;
                            node_waddr  <= node_cnt;
                            node_dim    <= dim_word[2:0];
                            node_median <= fifo_rdata;
                            if (dim_word >= DATA_WIDTH'(PATCH_SIZE))
                                protocol_err <= 1'b1;
                            if (node_cnt == LEAF_ADDR_W'(NUM_NODES - 1)) begin
                                node_cnt <= '0;
                                state    <= LEAVES;
                            end else begin
                                node_cnt <= node_cnt + 1'b1;
                            end
                        end
                    end
                    LEAVES: begin
                        // Last word of a leaf record carries the original patch index.
                        if (wcnt == WCNT_W'(PATCH_SIZE)) begin
                            wcnt           <= '0;
                            leaf_wen       <= 1'b1;
                            leaf_waddr     <= leaf_cnt;
                            leaf_slot      <= slot_cnt;
                            leaf_patch     <= pbuf;
                            leaf_patch_idx <= fifo_rdata;
                            if (slot_cnt == 3'(LEAF_SIZE - 1)) begin
                                slot_cnt <= '0;
                                if (leaf_cnt == LEAF_ADDR_W'(NUM_LEAVES - 1)) begin
                                    leaf_cnt      <= '0;
                                    kdtree_loaded <= 1'b1;
                                    state         <= QUERIES;
                                end else begin
                                    leaf_cnt <= leaf_cnt + 1'b1;
                                end
                            end else begin
                                slot_cnt <= slot_cnt + 1'b1;
                            end
                        end else begin
                            pbuf[wcnt] <= fifo_rdata;
                            wcnt       <= wcnt + 1'b1;
                        end
                    end
                    QUERIES: begin
                        if (wcnt == WCNT_W'(PATCH_SIZE - 1)) begin
                            wcnt        <= '0;
                            query_wen   <= 1'b1;
                            query_waddr <= query_cnt;
                            query_patch <= {fifo_rdata, pbuf[PATCH_SIZE-2:0]};
                            if (query_cnt == QUERY_ADDR_W'(NUM_QUERYS - 1)) begin
                                query_cnt      <= '0;
                                queries_loaded <= 1'b1;
                                state          <= DONE;
                            end else begin
                                query_cnt <= query_cnt + 1'b1;
                            end
                        end else begin
                            pbuf[wcnt] <= fifo_rdata;
                            wcnt       <= wcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_kd_input_dispatch.sv
// Scoreboard bench for kd_input_dispatch: a FIFO model feeds generated images while a
// monitor pops expected writes (built from the record format) and compares each strobe.
module tb_kd_input_dispatch;

    localparam int unsigned DW  = 11;
    localparam int unsigned PW  = 55;
    localparam int unsigned LAW = 6;
    localparam int unsigned QAW = 9;
    localparam int          BIG = 1 << 30;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_kdtree;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_rempty_n;
    logic            fifo_deq;
    logic            node_wen;
    logic [LAW-1:0]  node_waddr;
    logic [2:0]      node_dim;
    logic [DW-1:0]   node_median;
    logic            leaf_wen;
    logic [LAW-1:0]  leaf_waddr;
    logic [2:0]      leaf_slot;
    logic [PW-1:0]   leaf_patch;
    logic [DW-1:0]   leaf_patch_idx;
    logic            query_wen;
    logic [QAW-1:0]  query_waddr;
    logic [PW-1:0]   query_patch;
    logic            kdtree_loaded;
    logic            queries_loaded;
    logic            protocol_err;

    kd_input_dispatch dut (
        .clk            (clk),
        .rst            (rst),
        .load_kdtree    (load_kdtree),
        .fifo_rdata     (fifo_rdata),
        .fifo_rempty_n  (fifo_rempty_n),
        .fifo_deq       (fifo_deq),
        .node_wen       (node_wen),
        .node_waddr     (node_waddr),
        .node_dim       (node_dim),
        .node_median    (node_median),
        .leaf_wen       (leaf_wen),
        .leaf_waddr     (leaf_waddr),
        .leaf_slot      (leaf_slot),
        .leaf_patch     (leaf_patch),
        .leaf_patch_idx (leaf_patch_idx),
        .query_wen      (query_wen),
        .query_waddr    (query_waddr),
        .query_patch    (query_patch),
        .kdtree_loaded  (kdtree_loaded),
        .queries_loaded (queries_loaded),
        .protocol_err   (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        int            addr;
        int            slot;
        int            dim;
        logic [PW-1:0] data;
        int            idx;
        bit            kd;
        bit            ql;
        bit            perr;
        int            end_word;
    } rec_t;

    logic [DW-1:0] fifo_q[$];
    rec_t          exp_q[$];
    int            words_pushed   = 0;
    int            words_consumed = 0;
    int            pops_total     = 0;
    bit            throttle       = 1'b0;
    int            n_vec          = 0;
    int            n_fail         = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: first-word fall-through head, optional random empty cycles.
    always begin : feeder
        bit d;
        @(negedge clk);
        d = fifo_deq;
        @(posedge clk);
        #1;
        if (d && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            words_consumed++;
        end
        fifo_rempty_n = (fifo_q.size() > 0) && (!throttle || ($urandom_range(0, 2) != 0));
        fifo_rdata    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    int   mon_nw;
    int   mon_kind;
    rec_t mon_e;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            mon_nw = int'(node_wen) + int'(leaf_wen) + int'(query_wen);
            if (mon_nw > 0) begin
                chk("single_strobe", 64'(mon_nw), 64'd1);
                mon_kind = node_wen ? 0 : (leaf_wen ? 1 : 2);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: kind %0d strobed, expected no write (t=%0t)",
                             mon_kind, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    pops_total++;
                    chk("write_kind", 64'(mon_kind), 64'(mon_e.kind));
                    chk("strobe_timing", 64'(words_consumed), 64'(mon_e.end_word));
                    case (mon_e.kind)
                        0: begin
                            chk("node_waddr", 64'(node_waddr), 64'(mon_e.addr));
                            chk("node_dim", 64'(node_dim), 64'(mon_e.dim));
                            chk("node_median", 64'(node_median), mon_e.data);
                        end
                        1: begin
                            chk("leaf_waddr", 64'(leaf_waddr), 64'(mon_e.addr));
                            chk("leaf_slot", 64'(leaf_slot), 64'(mon_e.slot));
                            chk("leaf_patch", 64'(leaf_patch), 64'(mon_e.data));
                            chk("leaf_patch_idx", 64'(leaf_patch_idx), 64'(mon_e.idx));
                        end
                        default: begin
                            chk("query_waddr", 64'(query_waddr), 64'(mon_e.addr));
                            chk("query_patch", 64'(query_patch), 64'(mon_e.data));
                        end
                    endcase
                    chk("kdtree_loaded", 64'(kdtree_loaded), 64'(mon_e.kd));
                    chk("queries_loaded", 64'(queries_loaded), 64'(mon_e.ql));
                    chk("protocol_err", 64'(protocol_err), 64'(mon_e.perr));
                end
            end
        end
    end

    // style 0: test-plan patterns; 1: random; 2: random with occasional bad dimensions.
    // Only the first 'limit' words are queued, with the records they complete.
    task automatic load_image(input int style, input int bad_node, input int limit);
        int            base;
        int            w;
        bit            perr;
        rec_t          r;
        logic [DW-1:0] dimw;
        logic [DW-1:0] x;
        base = words_pushed;
        w    = 0;
        perr = 1'b0;
        for (int n = 0; n < 63; n++) begin
            if (style == 0) begin
                dimw = DW'(2);
                x    = DW'(700);
            end else begin
                dimw = DW'($urandom_range(0, 4));
                x    = DW'($urandom);
                if (style == 2 && $urandom_range(0, 15) == 0) dimw = DW'($urandom_range(5, 2047));
            end
            if (n == bad_node) dimw = DW'(7);
            if (dimw >= DW'(5)) perr = 1'b1;
            if (w < limit) fifo_q.push_back(dimw);
            w++;
            if (w < limit) fifo_q.push_back(x);
            w++;
            if (w <= limit) begin
                r.kind = 0; r.addr = n; r.slot = 0; r.dim = int'(dimw) % 8;
                r.data = PW'(x); r.idx = 0; r.kd = 1'b0; r.ql = 1'b0; r.perr = perr;
                r.end_word = base + w;
                exp_q.push_back(r);
            end
        end
        for (int p = 0; p < 512; p++) begin
            r.data = '0;
            for (int k = 0; k < 5; k++) begin
                x = (style == 0) ? DW'(p + k) : DW'($urandom);
                r.data[k*DW +: DW] = x;
                if (w < limit) fifo_q.push_back(x);
                w++;
            end
            x = (style == 0) ? DW'(p + 1000) : DW'($urandom);
            if (w < limit) fifo_q.push_back(x);
            w++;
            if (w <= limit) begin
                r.kind = 1; r.addr = p / 8; r.slot = p % 8; r.dim = 0; r.idx = int'(x);
                r.kd = (p == 511); r.ql = 1'b0; r.perr = perr; r.end_word = base + w;
                exp_q.push_back(r);
            end
        end
        for (int q = 0; q < 494; q++) begin
            r.data = '0;
            for (int k = 0; k < 5; k++) begin
                x = (style == 0) ? DW'(q * 5 + k) : DW'($urandom);
                r.data[k*DW +: DW] = x;
                if (w < limit) fifo_q.push_back(x);
                w++;
            end
            if (w <= limit) begin
                r.kind = 2; r.addr = q; r.slot = 0; r.dim = 0; r.idx = 0;
                r.kd = 1'b1; r.ql = (q == 493); r.perr = perr; r.end_word = base + w;
                exp_q.push_back(r);
            end
        end
        words_pushed = base + ((w < limit) ? w : limit);
    endtask

    task automatic pulse_load();
        @(posedge clk);
        #2 load_kdtree = 1'b1;
        @(posedge clk);
        #2 load_kdtree = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (fifo_q.size() == 0 && exp_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: %0d words and %0d writes outstanding, expected 0",
                     name, fifo_q.size(), exp_q.size());
        end
    endtask

    task automatic done_checks(input string name, input bit perr_exp);
        throttle = 1'b0;
        @(negedge clk);
        fifo_q.push_back(DW'(11'h123));
        repeat (3) @(negedge clk);
        chk({name, "_deq"}, 64'(fifo_deq), 64'd0);
        chk({name, "_word_left"}, 64'(fifo_q.size()), 64'd1);
        chk({name, "_kdtree_loaded"}, 64'(kdtree_loaded), 64'd1);
        chk({name, "_queries_loaded"}, 64'(queries_loaded), 64'd1);
        chk({name, "_protocol_err"}, 64'(protocol_err), 64'(perr_exp));
        fifo_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_wen"}, 64'({node_wen, leaf_wen, query_wen}), 64'd0);
        chk({name, "_deq"}, 64'(fifo_deq), 64'd0);
        chk({name, "_node"}, 64'({node_waddr, node_dim, node_median}), 64'd0);
        chk({name, "_leaf"}, 64'({leaf_waddr, leaf_slot, leaf_patch_idx}), 64'd0);
        chk({name, "_leaf_patch"}, 64'(leaf_patch), 64'd0);
        chk({name, "_query"}, 64'({query_waddr, query_patch}), 64'd0);
        chk({name, "_flags"}, 64'({kdtree_loaded, queries_loaded, protocol_err}), 64'd0);
    endtask

    initial begin
        int target;
        bit ok;
        rst         = 1'b0;
        load_kdtree = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Test-plan image, FIFO never empty
        pulse_load();
        load_image(0, -1, BIG);
        drain("plan_load", 20000);
        done_checks("plan_done", 1'b0);

        // Random image with bad dimensions, FIFO throttled
        throttle = 1'b1;
        pulse_load();
        load_image(2, 10, BIG);
        drain("rand_load", 20000);
        done_checks("rand_done", 1'b1);

        // Restart after 3 words of leaf patch 40, with protocol_err already set
        pulse_load();
        load_image(1, 5, 126 + 40 * 6 + 3);
        drain("partial_a", 2000);
        chk("partial_a_perr_set", 64'(protocol_err), 64'd1);
        pulse_load();
        @(negedge clk);
        chk("restart_a_perr", 64'(protocol_err), 64'd0);
        chk("restart_a_kd", 64'(kdtree_loaded), 64'd0);

        // Restart coinciding with the final word of leaf patch 40
        load_image(1, -1, 126 + 40 * 6 + 5);
        drain("partial_b", 2000);
        fifo_q.push_back(DW'(11'h555));
        words_pushed++;
        @(posedge clk);
        #2 load_kdtree = 1'b1;
        @(negedge clk);
        chk("restart_b_head_valid", 64'(fifo_rempty_n), 64'd1);
        chk("restart_b_deq", 64'(fifo_deq), 64'd0);
        fifo_q.delete();
        words_pushed--;
        @(posedge clk);
        #2 load_kdtree = 1'b0;

        // Asynchronous reset in the middle of the query phase
        throttle = 1'b1;
        load_image(2, -1, BIG);
        target = pops_total + 63 + 512 + 100;
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            if (pops_total >= target) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL midquery_timeout: %0d writes seen, expected %0d", pops_total, target);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        fifo_q.delete();
        exp_q.delete();
        words_pushed   = 0;
        words_consumed = 0;
        @(negedge clk);
        rst = 1'b0;

        // Full reload after reset, throttled
        pulse_load();
        load_image(0, -1, BIG);
        drain("reload", 20000);
        done_checks("reload_done", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/kd_input_dispatch.md
Name: kd_input_dispatch

Overview:
- Sits directly downstream of the input async FIFO, on the core clock.
- Drains the 11-bit word stream the host writes through the IO pins and splits it into three record types, in order: KD-tree internal nodes, leaf patches, and query patches.
- Each record is assembled into a single wide write for the node register file, the leaf memory or the query memory.
- Reports load completion and protocol errors to the main FSM.

Parameters:
- DATA_WIDTH, 11, width of one stream word
- PATCH_SIZE, 5, data words per patch
- LEAF_SIZE, 8, patches per leaf
- NUM_LEAVES, 64, leaves in the tree
- NUM_NODES, 63, internal nodes (NUM_LEAVES-1)
- NUM_QUERYS, 494, query patches per image
- LEAF_ADDR_W, 6, $clog2(NUM_LEAVES)
- QUERY_ADDR_W, 9, $clog2(NUM_QUERYS)

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- load_kdtree  in  1  one-cycle start pulse; (re)starts a full load
- fifo_rdata  in  DATA_WIDTH  FIFO head word (first-word fall-through)
- fifo_rempty_n  in  1  FIFO not empty
- fifo_deq  out  1  pop head word this cycle
- node_wen  out  1  internal-node write strobe
- node_waddr  out  LEAF_ADDR_W  node index, 0..NUM_NODES-1
- node_dim  out  3  split dimension
- node_median  out  DATA_WIDTH  split value
- leaf_wen  out  1  leaf patch write strobe
- leaf_waddr  out  LEAF_ADDR_W  leaf number
- leaf_slot  out  3  patch slot within leaf
- leaf_patch  out  PATCH_SIZE*DATA_WIDTH  patch data, word 0 in LSBs
- leaf_patch_idx  out  DATA_WIDTH  original-image patch index
- query_wen  out  1  query patch write strobe
- query_waddr  out  QUERY_ADDR_W  query number
- query_patch  out  PATCH_SIZE*DATA_WIDTH  query data, word 0 in LSBs
- kdtree_loaded  out  1  sticky: all nodes and leaves written
- queries_loaded  out  1  sticky: all queries written
- protocol_err  out  1  sticky: bad node dimension seen

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs are 0; FSM is in IDLE; all counters are 0.
- FSM states are IDLE, NODES, LEAVES, QUERIES and DONE.
  - IDLE or DONE + load_kdtree -> NODES; clears kdtree_loaded, queries_loaded, protocol_err and all counters.
- Dequeue rule:
  - fifo_deq = fifo_rempty_n && state in {NODES, LEAVES, QUERIES} && !load_kdtree (combinational).
  - A word is consumed at the clock edge where fifo_deq=1.
  - Empty FIFO: no consumption and no counter movement; the record assembly simply stalls.
- NODES records are 2 words: word0 = dimension, word1 = median.
  - The write issues after word1 with node_dim = word0[2:0].
  - If word0 >= PATCH_SIZE, protocol_err is set; the write still occurs.
  - After node NUM_NODES-1 is written -> LEAVES.
- LEAVES records are 6 words: words 0..4 = patch data, word 5 = patch index.
  - The patch counter p runs 0..NUM_LEAVES*LEAF_SIZE-1, with leaf_waddr = p/LEAF_SIZE and leaf_slot = p%LEAF_SIZE.
  - After the last patch: kdtree_loaded=1 and the FSM goes to QUERIES with no pulse needed.
- QUERIES records are 5 words.
  - query_waddr runs 0..NUM_QUERYS-1.
  - After the last query: queries_loaded=1 and the FSM goes to DONE.
- Write timing:
  - Each *_wen is registered and high for exactly 1 cycle, on the cycle after the record's final word is consumed.
  - Address and data outputs are valid with the strobe and hold until the next write.
  - At most one *_wen is high in any cycle.
- Back-to-back records: a word may be consumed every cycle; a record's strobe overlaps the first word of the next record.
- Mid-load restart: load_kdtree during NODES, LEAVES or QUERIES discards the partial record, writes nothing for it, returns to NODES next cycle and clears counters and flags.
  - If load_kdtree coincides with a record's final word, that word is not consumed (fifo_deq=0) and no write occurs.
- DONE: fifo_deq=0; extra FIFO words are left in place.
- Reset mid-operation: all state returns to reset values immediately; outputs are 0 without waiting for a clock edge.

Test Plan:
- Reset then load_kdtree; stream 126 node words (dim 2, median 700 repeated) -> 63 node_wen pulses with addr 0..62, node_dim=2, node_median=700, 1 cycle after each word1; protocol_err=0.
- Continue with 3072 leaf words, patch p = {p,p+1,p+2,p+3,p+4}, index p+1000 -> 512 leaf_wen pulses; p=13 gives leaf_waddr=1, leaf_slot=5, word0=13, leaf_patch_idx=1013; kdtree_loaded rises after p=511.
- Stream 2470 query words -> 494 query_wen pulses with addr 0..493; queries_loaded=1, FSM in DONE, fifo_deq=0 with rempty_n held high.
- Throttle fifo_rempty_n randomly (e.g. 1 of 3 cycles empty) over the full load -> identical write sequence; no strobe while stalled mid-record.
- Node word0=7 -> protocol_err=1 and node_dim=7; the flag stays set until the next load_kdtree.
- Pulse load_kdtree after 3 words of leaf patch 40; separately, assert async rst mid-query -> first case restarts at node 0 with no leaf write for patch 40 and flags cleared; second case drives all outputs to 0 immediately.
